// File: rtl/led_pattern_top.sv
// 8-LED chaser: a speed-selected divider ticks a step counter.
// The step counter walks one of four light patterns.
module led_pattern_top #(
  parameter int unsigned DIV0 = 500000,
  parameter int unsigned DIV1 = 50000,
  parameter int unsigned DIV2 = 5000,
  parameter int unsigned DIV3 = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Select,
  input  logic [1:0] MODE,
  output logic [7:0] LED
);

  typedef enum logic [1:0] {
    M_RUN    = 2'd0,
    M_FILL   = 2'd1,
    M_BOUNCE = 2'd2,
    M_OFF    = 2'd3
  } mode_e;

  mode_e       mode_q, mode_d;
  logic [1:0]  sel_q, sel_d;
  logic [18:0] div_cnt_q, div_cnt_d;
  logic [3:0]  step_q, step_d;

  logic [18:0] div_last;
  logic [3:0]  step_last;
  logic        restart;
  logic        tick;
  logic [3:0]  shamt;

  always_comb begin
    div_last = 19'(DIV0 - 1);
    unique case (sel_q)
      2'd0: div_last = 19'(DIV0 - 1);
      2'd1: div_last = 19'(DIV1 - 1);
      2'd2: div_last = 19'(DIV2 - 1);
      2'd3: div_last = 19'(DIV3 - 1);
    endcase
  end

  // Last step index of each pattern's cycle.
  always_comb begin
    step_last = 4'd0;
    unique case (mode_q)
      M_RUN:    step_last = 4'd7;
      M_FILL:   step_last = 4'd15;
      M_BOUNCE: step_last = 4'd13;
      M_OFF:    step_last = 4'd0;
    endcase
  end

  assign restart = (MODE != 2'(mode_q)) || (Select != sel_q);
  assign tick    = (div_cnt_q == div_last);

  always_comb begin
    mode_d    = mode_q;
    sel_d     = sel_q;
    div_cnt_d = div_cnt_q + 19'd1;
    step_d    = step_q;
    if (restart) begin
      mode_d    = mode_e'(MODE);
      sel_d     = Select;
      div_cnt_d = 19'd0;
      step_d    = 4'd0;
    end else if (tick) begin
      div_cnt_d = 19'd0;
      step_d    = (step_q == step_last) ? 4'd0 : step_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= mode_e'(MODE);
      sel_q     <= Select;
      div_cnt_q <= 19'd0;
      step_q    <= 4'd0;
    end else begin
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      div_cnt_q <= div_cnt_d;
      step_q    <= step_d;
    end
  end

  // Second half of fill/drain and bounce index from step 8.
  assign shamt = step_q - 4'd7;

  always_comb begin
    LED = 8'h00;
    unique case (mode_q)
      M_RUN:
        LED = 8'h01 << step_q[2:0];
      M_FILL:
        if (!step_q[3]) LED = 8'hFF >> (3'd7 - step_q[2:0]);
        else            LED = 8'hFF << shamt;
      M_BOUNCE:
        if (!step_q[3]) LED = 8'h01 << step_q[2:0];
        else            LED = 8'h80 >> shamt;
      M_OFF:
        LED = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_top.sv
// Randomised scoreboard bench for led_pattern_top.
// Model derives LED from clocks elapsed since the last restart.
module tb_led_pattern_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Select;
  logic [1:0] MODE;
  logic [7:0] LED;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  led_pattern_top #(
    .DIV0(64), .DIV1(32), .DIV2(8), .DIV3(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Select(Select),
    .MODE(MODE),
    .LED(LED)
  );

  function automatic int div_of(int s);
    case (s)
      0: return 64;
      1: return 32;
      2: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int len_of(int m);
    case (m)
      0: return 8;
      1: return 16;
      2: return 14;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] pat(int m, int s);
    int v;
    case (m)
      0: v = 1 << s;
      1: v = (s < 8) ? (1 << (s + 1)) - 1 : (255 << (s - 7));
      2: v = (s < 8) ? (1 << s) : (128 >> (s - 7));
      default: v = 0;
    endcase
    return v[7:0];
  endfunction

  // Reference model: one expectation per rising edge.
  initial begin
    int m_mode, m_sel, n, st;
    m_mode = -1;
    m_sel  = -1;
    n      = 0;
    forever begin
      @(posedge clk);
      if (reset || int'(MODE) != m_mode || int'(Select) != m_sel) begin
        m_mode = int'(MODE);
        m_sel  = int'(Select);
        n      = 0;
      end else begin
        n++;
      end
      st = (n / div_of(m_sel)) % len_of(m_mode);
      exp_q.push_back(pat(m_mode, st));
    end
  end

  // Monitor: compares the LED once per cycle on the falling edge.
  initial begin
    logic [7:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL no_expectation t=%0t LED=%02h", $time, LED);
      end else begin
        e = exp_q.pop_front();
        if (LED !== e) begin
          fails++;
          $display("FAIL led t=%0t mode=%0d sel=%0d LED=%02h expected=%02h",
                   $time, MODE, Select, LED, e);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    MODE   = 2'd0;
    Select = 2'd2;
    cyc(3);
    reset = 1'b0;
    cyc(80);

    MODE = 2'd1; Select = 2'd3;
    cyc(80);

    MODE = 2'd2; Select = 2'd1;
    cyc(14 * 32 + 40);

    MODE = 2'd3; Select = 2'd0;
    cyc(100);
    reset = 1'b1; cyc(1); reset = 1'b0;
    cyc(110);

    // Switch to bounce while the run pattern shows 10.
    MODE = 2'd0; Select = 2'd2;
    cyc(36);
    MODE = 2'd2;
    cyc(20);
    Select = 2'd0;
    cyc(150);

    // Single-cycle reset while the run pattern shows 08.
    MODE = 2'd0; Select = 2'd2;
    cyc(27);
    reset = 1'b1; cyc(1); reset = 1'b0;
    cyc(20);

    for (int i = 0; i < 40; i++) begin
      int hold;
      MODE   = 2'($urandom_range(0, 3));
      Select = 2'($urandom_range(0, 3));
      hold   = $urandom_range(20, 400);
      cyc(hold);
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        cyc($urandom_range(1, 3));
        reset = 1'b0;
        cyc($urandom_range(10, 100));
      end
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain leftover=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
